seq_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector. Generalises the fixed 4-bit "1011" Mealy detector.
- Pattern value, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loaded through a config port.
- Input bits are qualified by a valid strobe.
- Provides a combinational Mealy match flag, a registered copy of that flag, and a saturating match counter.
- Sits on a serial bit stream feeding framing/sync logic.

---
 rtl/seq_detector_prog.sv | 107 ++++++++++
 tb/tb_seq_detector_prog.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with a Mealy match flag,
// a registered copy of it and a saturating match counter.
module seq_detector_prog #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int unsigned        DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1,
    localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    input  logic               in_valid,
    input  logic               input_bit,
    output logic               detected,
    output logic               detected_r,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [MAX_LEN-1:0] nh, len_mask;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, nfill;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_r_q;
    logic               cfg_err_q, cfg_err_d;
    logic               acc, cfg_ok, pat_eq;

    // Match evaluation on the candidate history that includes the current bit.
    always_comb begin
        acc   = reset & enable & in_valid & ~cfg_load;
        nh    = {hist_q[MAX_LEN-2:0], input_bit};
        nfill = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        pat_eq   = ((nh ^ pat_q) & len_mask) == '0;
        detected = acc & (nfill >= len_q) & pat_eq;
    end

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (acc) begin
            hist_d = nh;
            // Non-overlap mode forgets the matched bits by emptying the fill.
            fill_d = (detected && !ovl_q) ? '0 : nfill;
        end

        if (count_clr) begin
            cnt_d = '0;
        end else if (detected && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVERLAP;
            cnt_q     <= '0;
            det_r_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cnt_q     <= cnt_d;
            det_r_q   <= detected;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign detected_r  = det_r_q;
    assign match_count = cnt_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed plan followed by random traffic, all
// checked against a queue-based reference model of the detector.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset, enable, cfg_load, cfg_overlap, count_clr, in_valid, input_bit;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       detected, detected_r, cfg_err;
    logic [15:0] match_count;
    logic       det2, det2_r, err2;
    logic [1:0] cnt2;

    int checks = 0;
    int passed = 0;

    // Reference model state: accepted bits since the last discard, oldest first.
    bit       mq[$];
    bit [7:0] m_pat;
    int       m_len, m_cnt, m_cnt2;
    bit       m_ovl, m_det_r, m_err;

    always #5 clk = ~clk;

    seq_detector_prog u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .in_valid    (in_valid),
        .input_bit   (input_bit),
        .detected    (detected),
        .detected_r  (detected_r),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    seq_detector_prog #(.CNT_W(2)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .in_valid    (in_valid),
        .input_bit   (input_bit),
        .detected    (det2),
        .detected_r  (det2_r),
        .match_count (cnt2),
        .cfg_err     (err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit model_det(bit r, bit e, bit v, bit b, bit l);
        bit t[$] = mq;
        if (!(r && e && v && !l)) return 1'b0;
        t.push_back(b);
        if (t.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (t[t.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input bit b, input bit l,
                        input bit c);
        bit exp;
        @(negedge clk);
        reset = r; enable = e; in_valid = v; input_bit = b; cfg_load = l; count_clr = c;
        #1;
        exp = model_det(r, e, v, b, l);
        chk("detected", detected, exp);
        chk("detected_sat", det2, exp);
        @(posedge clk);
        if (!r) begin
            mq.delete();
            m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
            m_cnt = 0; m_cnt2 = 0; m_det_r = 1'b0; m_err = 1'b0;
        end else begin
            m_det_r = exp;
            m_err   = 1'b0;
            if (l) begin
                if (cfg_len >= 1 && cfg_len <= 8) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                    mq.delete();
                end else begin
                    m_err = 1'b1;
                end
            end else if (e && v) begin
                if (exp && !m_ovl) mq.delete();
                else begin
                    mq.push_back(b);
                    if (mq.size() > 8) void'(mq.pop_front());
                end
            end
            if (c) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (exp) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
        chk("detected_r", detected_r, m_det_r);
        chk("match_count", match_count, m_cnt);
        chk("cfg_err", cfg_err, m_err);
        chk("match_count_sat", cnt2, m_cnt2);
    endtask

    task automatic load_cfg(input bit [7:0] p, input bit [3:0] n, input bit o);
        cfg_pattern = p; cfg_len = n; cfg_overlap = o;
        step(1, 1, 0, 0, 1, 0);
    endtask

    task automatic send(input bit b);
        step(1, 1, 1, b, 0, 0);
    endtask

    initial begin
        bit [6:0] s1;
        reset = 0; enable = 0; cfg_load = 0; cfg_overlap = 0; count_clr = 0;
        in_valid = 0; input_bit = 0; cfg_pattern = '0; cfg_len = '0;

        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        chk("reset_count", match_count, 0);
        chk("reset_det_r", detected_r, 0);

        // Default 1011 pattern with overlap.
        s1 = 7'b1011011;
        for (int i = 6; i >= 0; i--) send(s1[i]);
        chk("count_default_stream", match_count, 2);

        load_cfg(8'b111, 3, 1'b0);
        for (int i = 0; i < 7; i++) send(1'b1);
        chk("count_111_nonovl", match_count, 4);
        load_cfg(8'b111, 3, 1'b1);
        for (int i = 0; i < 7; i++) send(1'b1);
        chk("count_111_ovl", match_count, 9);

        // Gaps from in_valid=0 and enable=0 must not disturb history.
        load_cfg(8'b1011, 4, 1'b1);
        send(1); step(1, 1, 0, 0, 0, 0); step(1, 0, 1, 1, 0, 0);
        send(0); step(1, 1, 0, 1, 0, 0);
        send(1); step(1, 1, 0, 0, 0, 0);
        send(1);
        chk("count_gapped", match_count, 10);

        load_cfg(8'hFF, 0, 1'b1);
        chk("cfg_err_len0", cfg_err, 1);
        load_cfg(8'hFF, 9, 1'b0);
        chk("cfg_err_len9", cfg_err, 1);
        send(1); send(0); send(1); send(1);
        chk("count_after_bad_cfg", match_count, 11);
        cfg_pattern = 8'b1; cfg_len = 1; cfg_overlap = 1'b1;
        step(1, 1, 1, 1, 1, 0);
        chk("load_drops_bit", detected_r, 0);

        load_cfg(8'b1011, 4, 1'b1);
        send(1); send(0); send(1);
        step(0, 1, 1, 1, 0, 0);
        send(1);
        chk("reset_mid_count", match_count, 0);
        send(0); send(1); send(1);
        chk("reset_mid_resume", match_count, 1);

        // Saturation on the 2-bit counter instance, then clear during a match.
        load_cfg(8'b1, 1, 1'b1);
        step(1, 1, 1, 1, 0, 1);
        chk("clr_on_match", match_count, 0);
        for (int i = 0; i < 5; i++) send(1'b1);
        chk("sat_count", cnt2, 3);
        step(1, 1, 1, 1, 0, 1);
        chk("sat_clr", cnt2, 0);

        for (int n = 0; n < 400; n++) begin
            bit r, e, v, b, l, c;
            r = ($urandom_range(0, 49) != 0);
            l = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 29) == 0);
            b = 1'($urandom);
            if (l) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = 4'($urandom_range(0, 9));
                cfg_overlap = 1'($urandom);
            end
            step(r, e, v, b, l, c);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
